mix_columns_iter: RTL and testbench

Iterative, parametrised AES MixColumns / InvMixColumns engine with a valid/ready handshake on both sides. It latches a 128-bit state and a mode bit, then transforms COLS_PER_CYCLE columns per clock, trading area for latency. The result is held until the downstream stage accepts it. It sits between ShiftRows/InvShiftRows and AddRoundKey in the round datapath, and serves both encrypt and decrypt rounds.

---
 rtl/mix_columns_if.sv | 39 +++
 rtl/mix_columns_iter.sv | 230 +++++++++++++++++++++++
 tb/tb_mix_columns_iter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_if.sv
// -----------------------------------------------------------------------------
// mix_columns_if
//   Handshake bundle for the iterative MixColumns / InvMixColumns engine.
//
//   Input side  : in_valid / in_ready, with inverse, data_in and tag_in
//                 qualified by in_valid.
//   Output side : out_valid / out_ready, with data_out and tag_out
//                 qualified by out_valid.
//   Status      : busy, high whenever the engine is not idle.
//
//   master : the environment driving states in and taking results out.
//   slave  : the engine itself.
// -----------------------------------------------------------------------------
interface mix_columns_if #(
    parameter int TAG_W = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic             inverse;
    logic [127:0]     data_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     data_out;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    modport master (
        output in_valid, inverse, data_in, tag_in, out_ready,
        input  in_ready, out_valid, data_out, tag_out, busy
    );

    modport slave (
        input  in_valid, inverse, data_in, tag_in, out_ready,
        output in_ready, out_valid, data_out, tag_out, busy
    );

endinterface

// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//   Iterative AES MixColumns / InvMixColumns engine. A 128-bit state, a mode
//   bit and a sideband tag are latched on acceptance; COLS_PER_CYCLE columns
//   are then transformed per clock into the result register, and the result
//   is held until the downstream stage takes it.
//
//   Parameters
//     COLS_PER_CYCLE : columns per clock (1, 2 or 4); latency is
//                      4/COLS_PER_CYCLE cycles from acceptance.
//     TAG_W          : width of the opaque sideband tag (>= 1).
//
//   Ports
//     clk  : clock, rising edge.
//     rst  : asynchronous, active-high reset.
//     bus  : mix_columns_if slave modport
//            in_valid/in_ready/inverse/data_in/tag_in  - input handshake
//            out_valid/out_ready/data_out/tag_out      - output handshake
//            busy                                      - engine not idle
//
//   Byte layout: column c is [127-32c -: 32], byte r of a column is
//   [31-8r -: 8], identical on data_in and data_out.
// -----------------------------------------------------------------------------
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic         clk,
    input  logic         rst,
    mix_columns_if.slave bus
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("mix_columns_iter: TAG_W must be at least 1");
        end
    endgenerate

    // Guarded divisor so an illegal parameter reports the error above
    // instead of a divide-by-zero.
    localparam int         N_STEPS  = 4 / ((COLS_PER_CYCLE < 1) ? 1 : COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_HOLD
    } state_t;

    // -------------------------------------------------------------------------
    // GF(2^8) helpers, polynomial 0x11B
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] d0, d1, d2, d3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        d0 = xtime(b0);
        d1 = xtime(b1);
        d2 = xtime(b2);
        d3 = xtime(b3);
        // 3x is 2x ^ x
        return {d0 ^ (d1 ^ b1) ^ b2 ^ b3,
                b0 ^ d1 ^ (d2 ^ b2) ^ b3,
                b0 ^ b1 ^ d2 ^ (d3 ^ b3),
                (d0 ^ b0) ^ b1 ^ b2 ^ d3};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] b   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            b[r]  = col[31-8*r -: 8];
            x2    = xtime(b[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ b[r];
            mb[r] = x8 ^ x2 ^ b[r];
            md[r] = x8 ^ x4 ^ b[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // -------------------------------------------------------------------------
    // Registers and combinational nets
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [127:0]     r_src;
    logic             r_inv;
    logic [TAG_W-1:0] r_tag;
    logic [127:0]     r_result;
    logic [TAG_W-1:0] r_tag_out;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    logic [1:0]       w_col     [COLS_PER_CYCLE];
    logic [31:0]      w_col_in  [COLS_PER_CYCLE];
    logic [31:0]      w_fwd     [COLS_PER_CYCLE];
    logic [31:0]      w_inv     [COLS_PER_CYCLE];
    logic [31:0]      w_col_res [COLS_PER_CYCLE];
    logic [127:0]     w_result_nxt;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs. Outputs depend on r_state only,
    // so there is no combinational path from in_valid or out_ready.
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Column units: each computes both directions; the latched mode picks one.
    // Unit u works on column cnt*COLS_PER_CYCLE + u (mod 4 is exact here).
    // -------------------------------------------------------------------------
    always_comb begin
        w_result_nxt = r_result;
        for (int u = 0; u < COLS_PER_CYCLE; u++) begin
            w_col[u]    = 2'(r_cnt * 2'(COLS_PER_CYCLE) + 2'(u));
            w_col_in[u] = '0;
            for (int k = 0; k < 4; k++) begin
                if (w_col[u] == 2'(k)) begin
                    w_col_in[u] = r_src[127-32*k -: 32];
                end
            end
            w_fwd[u]     = mix_fwd(w_col_in[u]);
            w_inv[u]     = mix_inv(w_col_in[u]);
            w_col_res[u] = r_inv ? w_inv[u] : w_fwd[u];
            for (int k = 0; k < 4; k++) begin
                if (w_col[u] == 2'(k)) begin
                    w_result_nxt[127-32*k -: 32] = w_col_res[u];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Inputs are sampled only on acceptance; the result
    // and its tag change only on CALC writes, so both stay stable in HOLD.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_src     <= '0;
            r_inv     <= 1'b0;
            r_tag     <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_cnt <= '0;
            r_src <= bus.data_in;
            r_inv <= bus.inverse;
            r_tag <= bus.tag_in;
        end else if (r_state == S_CALC) begin
            r_result <= w_result_nxt;
            r_cnt    <= r_cnt + 2'd1;
            if (r_cnt == LAST_CNT) begin
                r_tag_out <= r_tag;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.data_out  = r_result;
    assign bus.tag_out   = r_tag_out;

endmodule

// File: tb/tb_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_iter
//   Three engines (COLS_PER_CYCLE = 1, 2, 4) share one stimulus bus; `sel`
//   routes in_valid/out_ready to one engine and picks its outputs. Expected
//   results come from a generic GF(2^8) circulant-matrix model.
// -----------------------------------------------------------------------------
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    int           sel;
    logic         in_valid;
    logic         inverse;
    logic         out_ready;
    logic [127:0] data_in;
    logic [3:0]   tag_in;

    logic [2:0]   v_in_ready;
    logic [2:0]   v_out_valid;
    logic [2:0]   v_busy;
    logic [127:0] v_data_out [3];
    logic [3:0]   v_tag_out  [3];

    logic         obs_in_ready;
    logic         obs_out_valid;
    logic         obs_busy;
    logic [127:0] obs_data_out;
    logic [3:0]   obs_tag_out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN   = 128'h8e4da1bc_9fdc589d_d4d4d4d5_4d7ebdf8;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_dut
            localparam int CPC = (k == 0) ? 1 : (k == 1) ? 2 : 4;
            mix_columns_if #(.TAG_W(4)) bus ();
            assign bus.in_valid  = in_valid && (sel == k);
            assign bus.inverse   = inverse;
            assign bus.data_in   = data_in;
            assign bus.tag_in    = tag_in;
            assign bus.out_ready = out_ready && (sel == k);
            assign v_in_ready[k]  = bus.in_ready;
            assign v_out_valid[k] = bus.out_valid;
            assign v_busy[k]      = bus.busy;
            assign v_data_out[k]  = bus.data_out;
            assign v_tag_out[k]   = bus.tag_out;
            mix_columns_iter #(.COLS_PER_CYCLE(CPC), .TAG_W(4)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    assign obs_in_ready  = v_in_ready[sel];
    assign obs_out_valid = v_out_valid[sel];
    assign obs_busy      = v_busy[sel];
    assign obs_data_out  = v_data_out[sel];
    assign obs_tag_out   = v_tag_out[sel];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(cf[(j - r + 4) % 4], s[127-32*c-8*j -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check({name, "_in_ready"},  128'(obs_in_ready),  128'd1);
            check({name, "_out_valid"}, 128'(obs_out_valid), 128'd0);
            check({name, "_busy"},      128'(obs_busy),      128'd0);
            check({name, "_data_out"},  obs_data_out,        128'd0);
            check({name, "_tag_out"},   128'(obs_tag_out),   128'd0);
        end
    endtask

    // One full transaction on engine k; called at a falling edge, returns at
    // the falling edge after release. Inputs are scrambled after acceptance.
    task automatic do_op(input int k, input logic inv, input logic [127:0] din,
                         input logic [3:0] tin, input int stall, input logic hold_valid,
                         output logic [127:0] dout, output logic [3:0] tout);
        int           n;
        int           cyc;
        logic [127:0] exp;
        n   = (k == 0) ? 4 : (k == 1) ? 2 : 1;
        exp = ref_mix(din, inv);
        sel       = k;
        inverse   = inv;
        data_in   = din;
        tag_in    = tin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check("accept_ready", 128'(obs_in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        inverse = ~inv;
        data_in = ~din;
        tag_in  = ~tin;
        if (!hold_valid) in_valid = 1'b0;
        cyc = 0;
        while (!obs_out_valid && cyc < 16) begin
            check("calc_ready_low", 128'(obs_in_ready), 128'd0);
            check("calc_busy", 128'(obs_busy), 128'd1);
            @(negedge clk);
            cyc++;
        end
        check("latency", 128'(cyc), 128'(n));
        check("out_valid", 128'(obs_out_valid), 128'd1);
        check("data_out", obs_data_out, exp);
        check("tag_out", 128'(obs_tag_out), 128'(tin));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_ready_low", 128'(obs_in_ready), 128'd0);
            check("hold_valid", 128'(obs_out_valid), 128'd1);
            check("hold_data", obs_data_out, exp);
            check("hold_tag", 128'(obs_tag_out), 128'(tin));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_ready", 128'(obs_in_ready), 128'd1);
        check("release_valid", 128'(obs_out_valid), 128'd0);
        dout = obs_data_out;
        tout = obs_tag_out;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d, d2, src;
        logic [3:0]   t, t2, tg;
        logic         seen;
        rst       = 1'b1;
        sel       = 0;
        in_valid  = 1'b0;
        inverse   = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        tag_in    = '0;

        // Reset state, both while asserted and after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset_released");
        @(negedge clk);

        // FIPS-197 forward vector on every width; latency checked in do_op.
        for (int k = 0; k < 3; k++) begin
            do_op(k, 1'b0, FIPS_IN, 4'd5, 0, 1'b0, d, t);
            check("fips_fwd_data", d, FIPS_OUT);
            check("fips_fwd_tag", 128'(t), 128'd5);
        end

        // Inverse vector. Columns 0, 1 and 3 have known inverse images; the
        // d4d4d4d5 <-> d5d5d7d6 pair is a forward pair, so column 2 is taken
        // from the model (full-state check inside do_op).
        for (int k = 0; k < 3; k++) begin
            do_op(k, 1'b1, INV_IN, 4'd5, 1, 1'b0, d, t);
            check("inv_cols01", 128'(d[127:64]), 128'(64'hdb135345_f20a225c));
            check("inv_col3", 128'(d[31:0]), 128'(32'h2d26314c));
        end

        // Mode flips to inverse during CALC (do_op scrambles); forward expected.
        src = {$urandom, $urandom, $urandom, $urandom};
        do_op(1, 1'b0, src, 4'ha, 0, 1'b0, d, t);
        check("mode_flip_fwd", d, ref_mix(src, 1'b0));

        // All-zero and all-ones states.
        do_op(2, 1'b0, '0, 4'hf, 0, 1'b0, d, t);
        do_op(0, 1'b1, '1, 4'h0, 0, 1'b0, d, t);

        // Backpressure: 10 stalled cycles with in_valid held and new data
        // pending, then the next state goes in right after release.
        src = {$urandom, $urandom, $urandom, $urandom};
        do_op(0, 1'b0, src, 4'h3, 10, 1'b1, d, t);
        src = {$urandom, $urandom, $urandom, $urandom};
        do_op(0, 1'b1, src, 4'hc, 0, 1'b0, d, t);

        // Asynchronous reset in the middle of CALC with cnt = 2.
        sel      = 0;
        inverse  = 1'b0;
        data_in  = FIPS_IN;
        tag_in   = 4'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 128'(obs_in_ready), 128'd1);
        check("arst_out_valid", 128'(obs_out_valid), 128'd0);
        check("arst_busy", 128'(obs_busy), 128'd0);
        check("arst_data_out", obs_data_out, 128'd0);
        check("arst_tag_out", 128'(obs_tag_out), 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (obs_out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("arst_no_valid", 128'(seen), 128'd0);
        do_op(0, 1'b0, FIPS_IN, 4'd7, 0, 1'b0, d, t);
        check("arst_recover", d, FIPS_OUT);

        // Random round trips with random tags and stalls.
        for (int i = 0; i < 200; i++) begin
            src = {$urandom, $urandom, $urandom, $urandom};
            tg  = 4'($urandom);
            do_op($urandom_range(0, 2), 1'b0, src, tg, $urandom_range(0, 3), 1'b0, d, t);
            do_op($urandom_range(0, 2), 1'b1, d, t, $urandom_range(0, 3), 1'b0, d2, t2);
            check("roundtrip_data", d2, src);
            check("roundtrip_tag", 128'(t2), 128'(tg));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
